// File: rtl/mixpix_pkg.sv
// Shared definitions for the MixPix pixel sequencer: state codes, default
// timing constants and a small width helper.
package mixpix_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_RST  = 3'd1;
  localparam state_t S_INT  = 3'd2;
  localparam state_t S_SH   = 3'd3;
  localparam state_t S_CMP  = 3'd4;
  localparam state_t S_RD   = 3'd5;
  localparam state_t S_DONE = 3'd6;

  localparam int T_RST_DEF  = 4;
  localparam int T_SH_DEF   = 2;
  localparam int T_TMO_DEF  = 255;
  localparam int DATA_W_DEF = 8;
  localparam int TINT_W_DEF = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pixel_seq_ctrl.sv
// Frame sequencer for one MixPix pixel channel: reset, integrate, sample/hold,
// compare and serial readout, with abort and conversion timeout.
module pixel_seq_ctrl
  import mixpix_pkg::*;
#(
  parameter int T_RST  = T_RST_DEF,
  parameter int T_SH   = T_SH_DEF,
  parameter int T_TMO  = T_TMO_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TINT_W = TINT_W_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              frame_req_i,
  input  logic              abort_i,
  input  logic [TINT_W-1:0] cfg_tint_i,
  input  logic              cfg_path_i,
  input  logic              conv_done_i,
  input  logic              data_i,
  output logic              Sh_rst_o,
  output logic              counter_rst_o,
  output logic              Vd1_o,
  output logic              Vd2_o,
  output logic              Sw1_o,
  output logic              Sw2_o,
  output logic              Sh_o,
  output logic              Sh_cmp_o,
  output logic              start_o,
  output logic              rd_en_o,
  output logic              busy_o,
  output logic              valid_o,
  output logic              timeout_o,
  output logic [DATA_W-1:0] pix_data_o
);

  localparam int CW = max3(TINT_W, $clog2(T_TMO + 1), $clog2(DATA_W + 1));

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [TINT_W-1:0] tint_m1;
  logic              path;
  logic [DATA_W-2:0] shreg;
  logic              accept, tmo_nxt, in_int;

  assign accept = (state == S_IDLE) && frame_req_i && !abort_i;

  // One shared phase counter; every transition reloads it to zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    tmo_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (accept) state_nxt = S_RST;
      end
      S_RST: if (cnt == CW'(T_RST - 1)) begin
        state_nxt = S_INT;
        cnt_nxt   = '0;
      end
      S_INT: if (cnt >= CW'(tint_m1)) begin
        state_nxt = S_SH;
        cnt_nxt   = '0;
      end
      S_SH: if (cnt == CW'(T_SH - 1)) begin
        state_nxt = S_CMP;
        cnt_nxt   = '0;
      end
      S_CMP: begin
        // cnt counts cycles waited after the start cycle
        if (conv_done_i) begin
          state_nxt = S_RD;
          cnt_nxt   = '0;
        end else if (cnt == CW'(T_TMO)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          tmo_nxt   = 1'b1;
        end
      end
      S_RD: if (cnt == CW'(DATA_W - 1)) begin
        state_nxt = S_DONE;
        cnt_nxt   = '0;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (abort_i && state != S_IDLE) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      tmo_nxt   = 1'b0;
    end
  end

  assign in_int = (state_nxt == S_INT);

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state         <= S_IDLE;
      cnt           <= '0;
      tint_m1       <= '0;
      path          <= 1'b0;
      shreg         <= '0;
      Sh_rst_o      <= 1'b0;
      counter_rst_o <= 1'b0;
      Vd1_o         <= 1'b0;
      Vd2_o         <= 1'b0;
      Sw1_o         <= 1'b0;
      Sw2_o         <= 1'b0;
      Sh_o          <= 1'b0;
      Sh_cmp_o      <= 1'b0;
      start_o       <= 1'b0;
      rd_en_o       <= 1'b0;
      busy_o        <= 1'b0;
      valid_o       <= 1'b0;
      timeout_o     <= 1'b0;
      pix_data_o    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        tint_m1 <= (cfg_tint_i == '0) ? '0 : cfg_tint_i - TINT_W'(1);
        path    <= cfg_path_i;
      end
      if (state == S_RD) shreg <= (DATA_W-1)'({shreg, data_i});
      if (state == S_RD && state_nxt == S_DONE) pix_data_o <= {shreg, data_i};
      Sh_rst_o      <= (state_nxt == S_RST);
      counter_rst_o <= (state_nxt == S_RST);
      Vd1_o         <= in_int && !path;
      Sw1_o         <= in_int && !path;
      Vd2_o         <= in_int && path;
      Sw2_o         <= in_int && path;
      Sh_o          <= (state_nxt == S_SH);
      Sh_cmp_o      <= (state_nxt == S_CMP);
      start_o       <= (state_nxt == S_CMP) && (state != S_CMP);
      rd_en_o       <= (state_nxt == S_RD);
      busy_o        <= (state_nxt != S_IDLE);
      valid_o       <= (state_nxt == S_DONE);
      timeout_o     <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Self-checking bench: frame plans are turned into expected per-cycle outputs
// by offset arithmetic from the frame start, then compared every cycle.
module tb_pixel_seq_ctrl;

  localparam int T_RST = 4;
  localparam int T_SH  = 2;
  localparam int T_TMO = 255;
  localparam int DW    = 8;
  localparam int TW    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame_req = 1'b0, abort = 1'b0, conv_done = 1'b0, data_in = 1'b0, cfg_path = 1'b0;
  logic [TW-1:0] cfg_tint = '0;
  logic sh_rst, crst, vd1, vd2, sw1, sw2, sh, sh_cmp, start, rd_en, busy, valid, tmo;
  logic [DW-1:0] pix;

  always #5 clk = ~clk;

  pixel_seq_ctrl #(.T_RST(T_RST), .T_SH(T_SH), .T_TMO(T_TMO), .DATA_W(DW), .TINT_W(TW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .frame_req_i(frame_req), .abort_i(abort),
    .cfg_tint_i(cfg_tint), .cfg_path_i(cfg_path), .conv_done_i(conv_done), .data_i(data_in),
    .Sh_rst_o(sh_rst), .counter_rst_o(crst), .Vd1_o(vd1), .Vd2_o(vd2), .Sw1_o(sw1), .Sw2_o(sw2),
    .Sh_o(sh), .Sh_cmp_o(sh_cmp), .start_o(start), .rd_en_o(rd_en), .busy_o(busy),
    .valid_o(valid), .timeout_o(tmo), .pix_data_o(pix)
  );

  // wait_c < 0 means conv_done is never given; *_at < 0 means unused
  typedef struct {
    int        tint;
    bit        path;
    int        wait_c;
    logic [7:0] data;
    int        abort_at;
    int        dup_at;
    int        rst_at;
    bit        req_abort;
  } plan_t;

  int checks = 0, errors = 0;
  bit active = 0, tmo_pend = 0;
  int t0 = 0, n = 0, rst_hold = 0;
  plan_t cur, nxt;
  logic [7:0] last_pix = '0;
  int c_shrst, c_sw1, c_sw2, c_vd1, c_vd2, c_sh, c_start, c_valid, c_tmo, c_busy, cyc_start, cyc_tmo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic clr_cnt();
    c_shrst = 0; c_sw1 = 0; c_sw2 = 0; c_vd1 = 0; c_vd2 = 0; c_sh = 0;
    c_start = 0; c_valid = 0; c_tmo = 0; c_busy = 0; cyc_start = -1; cyc_tmo = -1;
  endtask

  function automatic plan_t mk(int tint, bit path, int wait_c, logic [7:0] data);
    plan_t p;
    p.tint = tint; p.path = path; p.wait_c = wait_c; p.data = data;
    p.abort_at = -1; p.dup_at = -1; p.rst_at = -1; p.req_abort = 0;
    return p;
  endfunction

  // One cycle, entered at a falling edge: compare, drive inputs, advance model.
  task automatic step(input bit req, input bit req_abort);
    int o, ti, c0, rd0, dn, last;
    bit e_shrst, e_vd1, e_vd2, e_sh, e_cmp, e_start, e_rd, e_busy, e_valid;
    bit in_cmp, in_rd, is_done, ab, was_active;
    logic [7:0] epix;
    {e_shrst, e_vd1, e_vd2, e_sh, e_cmp, e_start, e_rd, e_busy, e_valid} = '0;
    in_cmp = 0; in_rd = 0; is_done = 0;
    epix = last_pix;
    o  = n - t0;
    ti = (cur.tint < 1) ? 1 : cur.tint;
    c0 = T_RST + ti + T_SH;
    if (cur.wait_c < 0) begin rd0 = -1; dn = -1; last = c0 + T_TMO; end
    else begin rd0 = c0 + cur.wait_c + 1; dn = rd0 + DW; last = dn; end
    if (active) begin
      e_busy = 1;
      if (o < T_RST) e_shrst = 1;
      else if (o < T_RST + ti) begin e_vd1 = !cur.path; e_vd2 = cur.path; end
      else if (o < c0) e_sh = 1;
      else if (cur.wait_c < 0 || o < rd0) begin e_cmp = 1; e_start = (o == c0); in_cmp = 1; end
      else if (o < dn) begin e_rd = 1; in_rd = 1; end
      else begin e_valid = 1; is_done = 1; epix = cur.data; end
    end
    chk("outputs{shrst,crst,vd1,vd2,sw1,sw2,sh,shcmp,start,rd,busy,valid,tmo}",
        {sh_rst, crst, vd1, vd2, sw1, sw2, sh, sh_cmp, start, rd_en, busy, valid, tmo},
        {e_shrst, e_shrst, e_vd1, e_vd2, e_vd1, e_vd2, e_sh, e_cmp, e_start, e_rd, e_busy, e_valid, tmo_pend});
    chk("pix_data", pix, epix);
    c_shrst += sh_rst; c_sw1 += sw1; c_sw2 += sw2; c_vd1 += vd1; c_vd2 += vd2; c_sh += sh;
    c_start += start; c_valid += valid; c_tmo += tmo; c_busy += busy;
    if (start) cyc_start = n;
    if (tmo) cyc_tmo = n;
    if (is_done) last_pix = cur.data;

    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) rst_n = 1'b1;
    end

    frame_req = 0; abort = 0;
    data_in   = 1'($urandom);
    cfg_tint  = TW'($urandom);
    cfg_path  = 1'($urandom);
    conv_done = in_cmp ? (cur.wait_c >= 0 && o == c0 + cur.wait_c) : ($urandom % 5 == 0);
    if (in_rd) data_in = cur.data[DW-1-(o-rd0)];
    if (active) begin
      if (o == cur.abort_at) abort = 1;
      if (o == cur.dup_at) frame_req = 1;
    end else if (req) begin
      frame_req = 1; abort = req_abort;
      cfg_tint = TW'(nxt.tint); cfg_path = nxt.path;
    end else abort = ($urandom % 4 == 0);

    ab = abort;
    was_active = active;
    if (active && o == cur.rst_at) begin
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs_zero",
          {sh_rst, crst, vd1, vd2, sw1, sw2, sh, sh_cmp, start, rd_en, busy, valid, tmo, pix}, '0);
      active = 0; tmo_pend = 0; last_pix = '0; rst_hold = 3;
    end else begin
      tmo_pend = was_active && cur.wait_c < 0 && o == last && !ab;
      if (was_active) begin
        if (ab || o == last) active = 0;
      end else if (frame_req && !ab && rst_n) begin
        active = 1; t0 = n + 1; cur = nxt;
      end
    end
    @(negedge clk);
    n++;
  endtask

  task automatic run_frame(input plan_t p);
    int guard;
    nxt = p;
    guard = 0;
    while ((active || !rst_n || rst_hold > 0) && guard < 2000) begin step(0, 0); guard++; end
    step(1, p.req_abort);
    guard = 0;
    while (active && guard < 2000) begin step(0, 0); guard++; end
    chk("frame_completes_within_budget", guard < 2000, 1);
    step(0, 0);
  endtask

  initial begin
    plan_t p;
    logic [7:0] prev;
    cur = mk(1, 0, 0, 8'h00);
    nxt = cur;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_state",
        {sh_rst, crst, vd1, vd2, sw1, sw2, sh, sh_cmp, start, rd_en, busy, valid, tmo, pix}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // nominal frame
    clr_cnt();
    run_frame(mk(10, 0, 3, 8'hA6));
    chk("nom_rst_len", c_shrst, 4);
    chk("nom_int_len_sw1", c_sw1, 10);
    chk("nom_int_len_vd1", c_vd1, 10);
    chk("nom_sh_len", c_sh, 2);
    chk("nom_path2_idle", c_sw2 + c_vd2, 0);
    chk("nom_valid_count", c_valid, 1);
    chk("nom_pix_data", pix, 8'hA6);
    chk("nom_latency", c_busy, 29);

    // path 1, zero integration time
    clr_cnt();
    run_frame(mk(0, 1, 0, 8'h3C));
    chk("p1_sw2_len", c_sw2, 1);
    chk("p1_vd2_len", c_vd2, 1);
    chk("p1_path1_idle", c_sw1 + c_vd1, 0);
    chk("p1_pix_data", pix, 8'h3C);

    // conversion timeout
    clr_cnt();
    prev = pix;
    run_frame(mk(5, 0, -1, 8'hFF));
    chk("tmo_pulse_count", c_tmo, 1);
    chk("tmo_no_valid", c_valid, 0);
    chk("tmo_wait_len", cyc_tmo - cyc_start, 256);
    chk("tmo_pix_held", pix, prev);

    // abort during INT, then a clean frame
    clr_cnt();
    p = mk(10, 1, 2, 8'h55); p.abort_at = T_RST + 3;
    run_frame(p);
    chk("abort_int_no_valid", c_valid, 0);
    chk("abort_int_pix_held", pix, 8'h3C);
    clr_cnt();
    run_frame(mk(7, 0, 1, 8'h81));
    chk("after_abort_int_valid", c_valid, 1);

    // abort during RD, then a clean frame
    clr_cnt();
    p = mk(3, 0, 2, 8'hC3); p.abort_at = T_RST + 3 + T_SH + 1 + 2 + 3;
    run_frame(p);
    chk("abort_rd_no_valid", c_valid, 0);
    chk("abort_rd_pix_held", pix, 8'h81);
    clr_cnt();
    run_frame(mk(2, 1, 4, 8'h5A));
    chk("after_abort_rd_pix", pix, 8'h5A);

    // request while busy is dropped
    clr_cnt();
    p = mk(6, 0, 1, 8'h12); p.dup_at = 5;
    run_frame(p);
    chk("busy_req_one_start", c_start, 1);
    chk("busy_req_one_valid", c_valid, 1);

    // request with abort in IDLE
    p = mk(6, 0, 1, 8'h99); p.req_abort = 1;
    run_frame(p);
    chk("req_abort_idle_busy", busy, 0);

    // async reset mid-CMP, then a clean frame
    p = mk(4, 1, -1, 8'h77); p.rst_at = T_RST + 4 + T_SH + 5;
    run_frame(p);
    clr_cnt();
    run_frame(mk(3, 0, 2, 8'hE7));
    chk("after_reset_valid", c_valid, 1);
    chk("after_reset_pix", pix, 8'hE7);

    // randomized frames
    for (int i = 0; i < 40; i++) begin
      p = mk(int'($urandom_range(0, 20)), 1'($urandom), int'($urandom_range(0, 10)), 8'($urandom));
      if ($urandom % 8 == 0) p.wait_c = -1;
      if ($urandom % 5 == 0) p.abort_at = int'($urandom_range(0, 40));
      if ($urandom % 5 == 0) p.dup_at = int'($urandom_range(0, 30));
      if ($urandom % 12 == 0) p.req_abort = 1;
      run_frame(p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
